// File: rtl/output_collector.sv
// Collects systolic-array result rows, applies optional ReLU plus signed saturation, and buffers
// them in a small FIFO drained over valid/ready, with back-pressure and a per-batch done pulse.
module output_collector #(
  parameter int unsigned COLS  = 4,
  parameter int unsigned ACC_W = 16,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           trigger_array,
  input  logic [6:0]                     num_inputs,
  input  logic                           activated,
  input  logic [COLS*ACC_W-1:0]          array_out,
  input  logic                           relu_en,
  output logic                           stall,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [COLS*OUT_W-1:0]          out_data,
  output logic [$clog2(DEPTH+1)-1:0]     occupancy,
  output logic                           batch_done
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned OccW = $clog2(DEPTH + 1);
  localparam logic signed [ACC_W-1:0] SatMax = ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SatMin = ~SatMax;

  typedef enum logic [1:0] {StIdle, StCollect, StDrain} state_e;

  state_e                    r_state, w_state_next;
  logic [6:0]                r_count, r_rows_in, w_rows_next;
  logic                      r_relu;
  logic [COLS*OUT_W-1:0]     r_mem [DEPTH];
  logic [PtrW-1:0]           r_wptr, r_rptr;
  logic [OccW-1:0]           r_occ;
  logic                      r_batch_done;
  logic                      w_full, w_empty, w_push, w_pop;
  logic                      w_stall, w_done_next;
  logic [COLS*OUT_W-1:0]     w_row;
  logic signed [ACC_W-1:0]   w_col;

  assign w_full      = (r_occ == OccW'(DEPTH));
  assign w_empty     = (r_occ == '0);
  // Full guard is redundant with the stall gating upstream but keeps the FIFO safe regardless.
  assign w_push      = (r_state == StCollect) && activated && (r_rows_in != r_count) && !w_full;
  assign w_pop       = !w_empty && out_ready;
  assign w_rows_next = r_rows_in + 7'(w_push);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (trigger_array) w_state_next = StCollect;
      StCollect: if (w_rows_next == r_count) w_state_next = StDrain;
      StDrain:   if (w_empty) w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_stall     = (r_state == StCollect) && w_full;
    w_done_next = (r_state == StDrain) && w_empty;
  end

  always_comb begin
    w_row = '0;
    w_col = '0;
    for (int i = 0; i < COLS; i++) begin
      w_col = array_out[i*ACC_W +: ACC_W];
      if (r_relu && w_col[ACC_W-1]) w_col = '0;
      if (w_col > SatMax)      w_row[i*OUT_W +: OUT_W] = SatMax[OUT_W-1:0];
      else if (w_col < SatMin) w_row[i*OUT_W +: OUT_W] = SatMin[OUT_W-1:0];
      else                     w_row[i*OUT_W +: OUT_W] = w_col[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count      <= '0;
      r_relu       <= 1'b0;
      r_rows_in    <= '0;
      r_batch_done <= 1'b0;
    end else begin
      r_batch_done <= w_done_next;
      if (r_state == StIdle && trigger_array) begin
        r_count   <= num_inputs;
        r_relu    <= relu_en;
        r_rows_in <= '0;
      end else if (w_push) begin
        r_rows_in <= w_rows_next;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_row;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_occ <= r_occ + OccW'(w_push) - OccW'(w_pop);
    end
  end

  assign stall      = w_stall;
  assign out_valid  = !w_empty;
  assign out_data   = r_mem[r_rptr];
  assign occupancy  = r_occ;
  assign batch_done = r_batch_done;

endmodule

// File: doc/output_collector.md
# output_collector

Downstream consumer of the systolic array's result rows. While `activated` is high, it captures one row of accumulator outputs per cycle, applies optional ReLU and signed saturation, and buffers the packed row in a small FIFO. It drains the FIFO over a valid/ready interface and back-pressures the array through `stall`, which feeds the activation timer's `stall` input. It counts rows per batch and pulses `batch_done` once every row of the batch has been drained.

## Interface
Parameters:
- `COLS`, 4: number of array columns (results per row)
- `ACC_W`, 16: signed accumulator width per column
- `OUT_W`, 8: signed output width per column
- `DEPTH`, 4: FIFO depth in rows (≥2, power of 2)

Ports:
- `clk`  in  1  rising-edge clock
- `n_rst`  in  1  asynchronous active-low reset
- `trigger_array`  in  1  batch start, same pulse that launches the array
- `num_inputs`  in  7  rows expected in this batch, sampled on accepted trigger
- `activated`  in  1  array row valid this cycle (already gated with ~stall)
- `array_out`  in  COLS*ACC_W  column i at [i*ACC_W +: ACC_W], signed
- `relu_en`  in  1  1 = clamp negatives to 0 before saturation; sampled on accepted trigger
- `stall`  out  1  FIFO full; freezes array and timer
- `out_valid`  out  1  FIFO head valid
- `out_ready`  in  1  consumer accepts head
- `out_data`  out  COLS*OUT_W  FIFO head row, column i at [i*OUT_W +: OUT_W]
- `occupancy`  out  $clog2(DEPTH+1)  rows in FIFO
- `batch_done`  out  1  one-cycle pulse, batch fully drained

## Operation
- States: IDLE, COLLECT, DRAIN. Reset → IDLE.
- IDLE: `trigger_array`=1 → COLLECT. Latch `num_inputs` and `relu_en`. Clear `rows_in` (7-bit).
- COLLECT: each cycle with `activated`=1 pushes the processed row and increments `rows_in`. When `rows_in` reaches the latched count (including the push in this cycle), go to DRAIN. A latched count of 0 goes to DRAIN on the first COLLECT cycle.
- DRAIN: no pushes. When FIFO empty → IDLE.
- `activated` outside COLLECT is ignored. `trigger_array` outside IDLE is ignored.
- Per-column processing:
  - if relu and value<0, value=0;
  - then saturate to [−2^(OUT_W−1), 2^(OUT_W−1)−1];
  - otherwise truncate to OUT_W bits (value already in range).
- FIFO behaviour:
  - pop when `out_valid && out_ready`;
  - push and pop in the same cycle is allowed when neither full nor empty, and `occupancy` is unchanged;
  - push to a full FIFO cannot occur, because `activated` is 0 while `stall`=1.
  - Pointers wrap modulo DEPTH.
- `stall` = (state==COLLECT) && (occupancy==DEPTH). This is combinational from registered state only and has no dependence on `out_ready`.
- `out_valid` = (occupancy≠0). `out_data` = head entry, combinational from storage.

## Timing
- Reset values:
  - state IDLE;
  - `occupancy` 0;
  - `out_valid` 0;
  - `stall` 0;
  - `batch_done` 0;
  - `out_data` 0 (storage cleared).
- Push latency: a row with `activated`=1 at edge k gives `out_valid`=1 and that row on `out_data` after edge k, with no combinational path from `array_out` to `out_data`.
- `stall` rises in the cycle after the push that fills the FIFO. It falls in the cycle after a pop from full.
- `batch_done`: registered, high for exactly one cycle, the first cycle in IDLE after DRAIN.
- Throughput: one row per cycle sustained when `out_ready`=1.
- Reset mid-batch: FIFO contents discarded, state IDLE, no `batch_done`.

## Test plan
- Basic batch: COLS=4, `num_inputs`=3, `relu_en`=0, `out_ready`=1. Push rows {5,−3,200,−200}. Expect `out_data` {5,−3,127,−128}, 3 pops, and `batch_done` one cycle after the last pop.
- ReLU: `relu_en`=1, row {−1,0,1,−32768}. Expect {0,0,1,0}.
- Back-pressure: `out_ready`=0, `num_inputs`=6, `activated` held high. Expect `stall`=1 after the 4th push and `occupancy`=4. Release `out_ready`; expect `stall` to drop the cycle after the first pop, all 6 rows in order, and `batch_done` once.
- Simultaneous push/pop at `occupancy`=2. Expect `occupancy` stays 2 and order is preserved across pointer wrap.
- Batch boundaries: `num_inputs`=0 returns COLLECT→DRAIN→IDLE with `batch_done` and no output. A second `trigger_array` during DRAIN is ignored. `activated` in IDLE pushes nothing.
- Reset mid-batch with `occupancy`=3. Expect all outputs at reset values. A following batch with `num_inputs`=1 completes normally.
